dpll_loop_filter: RTL and testbench
===================================

Name: dpll_loop_filter

Overview:
- Digital loop filter (K-counter / random-walk filter) between the phase detector `dpd` and the oscillator `dco` in the all-digital PLL.
- Consumes single-cycle `lead` / `lag` / `bothedge` pulses from `dpd`.
- Integrates them in a signed up/down counter and emits single-cycle `add` / `plus` correction pulses to `dco` only when accumulated error exceeds threshold K.
- Gear-shift FSM uses a small K during acquisition and a large K once locked, and reports lock status.

Parameters:
- CNT_W, 8, width of signed error counter; requires K_TRK < 2^(CNT_W-1).
- K_ACQ, 4, threshold magnitude in ACQ state.
- K_TRK, 16, threshold magnitude in TRACK state.
- LOCK_CNT, 32, consecutive non-correcting phase events needed to enter TRACK.
- UNLOCK_CNT, 3, consecutive same-sign corrections in TRACK that force return to ACQ.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  filter enable; low forces IDLE.
- lead  in  1  1-cycle pulse from dpd: ref leads, frequency must rise.
- lag  in  1  1-cycle pulse from dpd: ref lags, frequency must fall.
- bothedge  in  1  1-cycle pulse from dpd: edges coincident, zero error.
- add  out  1  1-cycle pulse to dco `add`: speed up.
- plus  out  1  1-cycle pulse to dco `plus`: slow down.
- locked  out  1  high while in TRACK.
- state_o  out  2  current FSM state (IDLE=0, ACQ=1, TRACK=2).
- err_cnt  out  CNT_W  signed counter value, debug.

Behaviour:
- Reset (`clk` edge with `reset`=1): `add`=`plus`=`locked`=0, `err_cnt`=0, `state_o`=IDLE, lock and run counters=0.
- Event decode, same cycle:
  - `lead` & !`lag` → +1.
  - `lag` & !`lead` → -1.
  - `lead` & `lag` → treated as `bothedge` (0).
  - `bothedge` with `lead` or `lag` → `lead`/`lag` wins.
  - Phase event = any of the three inputs high.
- Active K = K_ACQ in ACQ, K_TRK in TRACK.
- Counter update: next = `err_cnt` + step.
  - If next >= +K: `add`=1 on the next cycle (1-cycle registered latency) and `err_cnt` ← 0.
  - If next <= -K: `plus`=1 next cycle and `err_cnt` ← 0.
  - Otherwise `err_cnt` ← next.
  - `add` and `plus` are never both high; each is high for exactly one cycle per crossing.
- FSM:
  - IDLE: counters held at 0, no pulses. `en`=1 → ACQ.
  - ACQ: lock counter +1 per phase event that produces no correction; cleared on any correction. When the lock counter reaches LOCK_CNT → TRACK, `err_cnt` ← 0, lock counter ← 0.
  - TRACK: `locked`=1. Run counter tracks consecutive corrections of the same sign: +1 on same sign, set to 1 on opposite sign, unaffected by non-correcting events. When it reaches UNLOCK_CNT → ACQ, `err_cnt` ← 0, run counter ← 0, `locked` falls the same cycle the state changes.
  - `en`=0 in any state → IDLE next cycle, all counters cleared. Any pulse already registered still completes its single cycle.
- The correction that triggers TRACK→ACQ is still emitted.
- Reset mid-operation overrides everything, including a pending pulse.
- Counter arithmetic is signed CNT_W-bit. Wrap is impossible given the parameter constraint; an elaboration-time check flags a violation.

Optional Feature:
- Macro DPLL_LF_STATS_EN.
- Defined: adds outputs `n_add` (16 bits) and `n_plus` (16 bits).
  - Each counts emitted corrections and saturates at 0xFFFF.
  - Both clear on reset or on entry to IDLE.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `dpll_pkg`:
  - FSM state encoding (IDLE/ACQ/TRACK) as a typedef.
  - Default K_ACQ/K_TRK/LOCK_CNT/UNLOCK_CNT constants, shared with `dco` and the bench.
- Sub-module `dpll_kcounter`:
  - Signed up/down counter with programmable threshold input, clear input and registered `carry`/`borrow` pulse outputs.
  - Instanced once; the FSM wraps it.

Test Plan:
- Reset/idle: hold `reset`=1 for 5 cycles, then `en`=0 with 10 `lead` pulses → `add`=`plus`=0, `err_cnt`=0, `state_o`=0 throughout.
- ACQ carry: `en`=1, 4 `lead` pulses spaced 10 cycles apart → exactly one `add` pulse, 1 cycle after the 4th `lead`; `err_cnt` returns to 0. Repeat with `lag` → one `plus`.
- Cancellation: 3 `lead` then 3 `lag` → no pulse, `err_cnt`=0. A cycle with `lead`&`lag` simultaneous → `err_cnt` unchanged.
- Lock: 32 alternating `lead`/`lag`/`bothedge` events with no crossing → `locked` rises after the 32nd event. Then 15 `lead` → no pulse; the 16th `lead` → one `add`.
- Unlock: in TRACK, 48 `lead` pulses → `add` pulses after `lead`s #16, #32 and #48. After the 3rd pulse, `state_o`=ACQ, `locked`=0; 4 further `lead`s → `add`.
- Mid-operation: `err_cnt`=3 in ACQ, `en`=0 for 1 cycle → `state_o`=IDLE, `err_cnt`=0. With DPLL_LF_STATS_EN defined, `n_add` clears on IDLE entry and otherwise increments per `add`.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared definitions for the all-digital PLL: loop-filter FSM state encoding
// and the default loop-filter thresholds used by the filter, dco and bench.
package dpll_pkg;

    // Loop-filter operating state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAcq   = 2'd1,
        StTrack = 2'd2
    } dpll_state_e;

    localparam int unsigned DefCntW      = 8;
    localparam int unsigned DefKAcq      = 4;
    localparam int unsigned DefKTrk      = 16;
    localparam int unsigned DefLockCnt   = 32;
    localparam int unsigned DefUnlockCnt = 3;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dpll_kcounter.sv
// Signed up/down K-counter. Integrates +1/-1 steps and, when the running sum
// reaches +k or -k, clears itself and emits a registered carry/borrow pulse.
// cross_up/cross_dn flag the crossing combinationally so the wrapping FSM can
// act on it in the same cycle the pulse is registered.
module dpll_kcounter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    inc,
    input  logic                    dec,
    input  logic signed [CNT_W-1:0] k,
    output logic signed [CNT_W-1:0] cnt,
    output logic                    cross_up,
    output logic                    cross_dn,
    output logic                    carry,
    output logic                    borrow
);

    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [CNT_W-1:0] step;
    logic signed [CNT_W-1:0] sum;
    logic                    carry_q, borrow_q;

    // Step decode; inc and dec are mutually exclusive from the caller.
    always_comb begin
        step = '0;
        if (inc) begin
            step = CNT_W'(1);
        end else if (dec) begin
            step = {CNT_W{1'b1}};
        end
    end

    assign sum      = cnt_q + step;
    assign cross_up = inc & (sum >= k);
    assign cross_dn = dec & (sum <= -k);

    // Next count: a crossing or an external clear restarts integration at 0.
    always_comb begin
        cnt_d = sum;
        if (clr || cross_up || cross_dn) begin
            cnt_d = '0;
        end
    end

    // Counter and single-cycle correction pulses; clr does not cancel a crossing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= cross_up;
            borrow_q <= cross_dn;
        end
    end

    assign cnt    = cnt_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;

endmodule

// File: rtl/dpll_loop_filter.sv
// DPLL loop filter: random-walk K-counter between dpd and dco with a
// gear-shift FSM (small K while acquiring, large K once locked).
// Optional build macro DPLL_LF_STATS_EN adds saturating correction counters
// n_add / n_plus.
module dpll_loop_filter
    import dpll_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned K_ACQ      = DefKAcq,
    parameter int unsigned K_TRK      = DefKTrk,
    parameter int unsigned LOCK_CNT   = DefLockCnt,
    parameter int unsigned UNLOCK_CNT = DefUnlockCnt
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    lead,
    input  logic                    lag,
    input  logic                    bothedge,
    output logic                    add,
    output logic                    plus,
    output logic                    locked,
    output logic [1:0]              state_o,
`ifdef DPLL_LF_STATS_EN
    output logic [15:0]             n_add,
    output logic [15:0]             n_plus,
`endif
    output logic signed [CNT_W-1:0] err_cnt
);

    localparam int unsigned LW = cnt_width(LOCK_CNT);
    localparam int unsigned RW = cnt_width(UNLOCK_CNT);

    // Thresholds must stay representable as positive signed CNT_W values so
    // the counter can never wrap.
    if (K_TRK >= (1 << (CNT_W - 1)) || K_ACQ >= (1 << (CNT_W - 1)) ||
        K_ACQ == 0 || K_TRK == 0 || LOCK_CNT == 0 || UNLOCK_CNT == 0) begin : g_param_check
        $error("dpll_loop_filter: illegal parameter combination");
    end

    dpll_state_e             state_q, state_d;
    logic [LW-1:0]           lock_q, lock_d;
    logic [RW-1:0]           run_q, run_d;
    logic [RW-1:0]           run_next;
    logic                    run_up_q, run_up_d;
    logic                    locked_q;

    logic                    step_up, step_dn, phase_ev, active;
    logic                    inc, dec, clr;
    logic                    cross_up, cross_dn, correction;
    logic                    carry, borrow;
    logic signed [CNT_W-1:0] k_sel;

    // Event decode: lead&lag is a zero-error event; bothedge loses to a lone lead/lag.
    assign step_up  = lead & ~lag;
    assign step_dn  = lag & ~lead;
    assign phase_ev = lead | lag | bothedge;

    // Steps only reach the counter while enabled and out of IDLE.
    assign active     = en & (state_q != StIdle);
    assign inc        = active & step_up;
    assign dec        = active & step_dn;
    assign k_sel      = (state_q == StTrack) ? CNT_W'(K_TRK) : CNT_W'(K_ACQ);
    assign correction = cross_up | cross_dn;

    dpll_kcounter #(
        .CNT_W (CNT_W)
    ) u_kcounter (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .inc      (inc),
        .dec      (dec),
        .k        (k_sel),
        .cnt      (err_cnt),
        .cross_up (cross_up),
        .cross_dn (cross_dn),
        .carry    (carry),
        .borrow   (borrow)
    );

    // Gear-shift next-state: lock qualification in ACQ, same-sign run detection in TRACK.
    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        run_d    = run_q;
        run_up_d = run_up_q;
        run_next = run_q;
        clr      = 1'b0;
        if (!en) begin
            state_d  = StIdle;
            lock_d   = '0;
            run_d    = '0;
            run_up_d = 1'b0;
            clr      = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StAcq;
                    clr     = 1'b1;
                end
                StAcq: begin
                    if (correction) begin
                        lock_d = '0;
                    end else if (phase_ev) begin
                        if (lock_q == LW'(LOCK_CNT - 1)) begin
                            state_d = StTrack;
                            lock_d  = '0;
                            clr     = 1'b1;
                        end else begin
                            lock_d = lock_q + 1'b1;
                        end
                    end
                end
                StTrack: begin
                    if (correction) begin
                        // run_q == 0 means no correction seen yet in this TRACK stint.
                        if (run_q != '0 && run_up_q == cross_up) begin
                            run_next = run_q + 1'b1;
                        end else begin
                            run_next = RW'(1);
                        end
                        run_d    = run_next;
                        run_up_d = cross_up;
                        if (run_next == RW'(UNLOCK_CNT)) begin
                            state_d  = StAcq;
                            run_d    = '0;
                            run_up_d = 1'b0;
                            clr      = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    // FSM state, lock/run counters and the registered locked flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            lock_q   <= '0;
            run_q    <= '0;
            run_up_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            run_q    <= run_d;
            run_up_q <= run_up_d;
            locked_q <= (state_d == StTrack);
        end
    end

    assign add     = carry;
    assign plus    = borrow;
    assign locked  = locked_q;
    assign state_o = state_q;

`ifdef DPLL_LF_STATS_EN
    logic [15:0] n_add_q, n_plus_q;

    // Saturating correction statistics, held clear while heading into or sitting in IDLE.
    always_ff @(posedge clk) begin
        if (reset || state_d == StIdle) begin
            n_add_q  <= '0;
            n_plus_q <= '0;
        end else begin
            if (carry && n_add_q != 16'hFFFF) begin
                n_add_q <= n_add_q + 16'd1;
            end
            if (borrow && n_plus_q != 16'hFFFF) begin
                n_plus_q <= n_plus_q + 16'd1;
            end
        end
    end

    assign n_add  = n_add_q;
    assign n_plus = n_plus_q;
`endif

endmodule

// File: tb/tb_dpll_loop_filter.sv
// Directed bench for dpll_loop_filter with default parameters.
module tb_dpll_loop_filter;
    import dpll_pkg::*;

    logic              clk;
    logic              reset;
    logic              en;
    logic              lead;
    logic              lag;
    logic              bothedge;
    logic              add;
    logic              plus;
    logic              locked;
    logic [1:0]        state_o;
    logic signed [7:0] err_cnt;
`ifdef DPLL_LF_STATS_EN
    logic [15:0]       n_add;
    logic [15:0]       n_plus;
`endif

    int total = 0;
    int bad   = 0;
    int add_seen  = 0;
    int plus_seen = 0;
    int a0, p0;

    dpll_loop_filter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .lead     (lead),
        .lag      (lag),
        .bothedge (bothedge),
        .add      (add),
        .plus     (plus),
        .locked   (locked),
        .state_o  (state_o),
`ifdef DPLL_LF_STATS_EN
        .n_add    (n_add),
        .n_plus   (n_plus),
`endif
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: values seen at a rising edge are the previous cycle's outputs.
    always @(posedge clk) begin
        if (add)  add_seen++;
        if (plus) plus_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One-cycle phase event; returns at the negedge after the consuming edge.
    task automatic ev(input logic l, input logic g, input logic b);
        @(negedge clk);
        lead = l; lag = g; bothedge = b;
        @(negedge clk);
        lead = 1'b0; lag = 1'b0; bothedge = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 32 lead/lag/bothedge events that never cross K_ACQ.
    task automatic lock_seq();
        for (int i = 0; i < 32; i++) begin
            ev(i % 3 == 0, i % 3 == 1, i % 3 == 2);
            if (i == 30) chk("not_locked_after_31", locked, 0);
        end
        chk("locked_after_32", locked, 1);
        chk("state_track", state_o, 2);
        chk("err_clear_on_lock", err_cnt, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; lead = 1'b0; lag = 1'b0; bothedge = 1'b0;
        gap(5);
        chk("rst_add", add, 0);
        chk("rst_plus", plus, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_state", state_o, 0);
        reset = 1'b0;

        // Disabled: leads are ignored.
        a0 = add_seen; p0 = plus_seen;
        for (int i = 0; i < 10; i++) ev(1, 0, 0);
        gap(2);
        chk("idle_err", err_cnt, 0);
        chk("idle_state", state_o, 0);
        chk("idle_no_add", add_seen - a0, 0);
        chk("idle_no_plus", plus_seen - p0, 0);

        en = 1'b1;
        gap(1);
        chk("enter_acq", state_o, 1);

        // ACQ carry: 4 leads spaced 10 cycles apart.
        a0 = add_seen;
        for (int i = 0; i < 4; i++) begin
            ev(1, 0, 0);
            if (i < 3) begin
                chk("acq_lead_err", err_cnt, i + 1);
                chk("acq_lead_no_add", add, 0);
                gap(9);
            end
        end
        chk("acq_add_pulse", add, 1);
        chk("acq_add_err0", err_cnt, 0);
        gap(2);
        chk("acq_add_once", add_seen - a0, 1);
`ifdef DPLL_LF_STATS_EN
        chk("stats_n_add1", n_add, 1);
`endif

        // ACQ borrow with lags.
        p0 = plus_seen;
        for (int i = 0; i < 4; i++) begin
            ev(0, 1, 0);
            if (i < 3) chk("acq_lag_err", err_cnt, -(i + 1));
        end
        chk("acq_plus_pulse", plus, 1);
        chk("acq_plus_noadd", add, 0);
        chk("acq_plus_err0", err_cnt, 0);
        gap(2);
        chk("acq_plus_once", plus_seen - p0, 1);
`ifdef DPLL_LF_STATS_EN
        chk("stats_n_plus1", n_plus, 1);
`endif

        // Cancellation and simultaneous/priority decode.
        a0 = add_seen; p0 = plus_seen;
        repeat (3) ev(1, 0, 0);
        chk("cancel_up3", err_cnt, 3);
        repeat (3) ev(0, 1, 0);
        chk("cancel_zero", err_cnt, 0);
        repeat (2) ev(1, 0, 0);
        ev(1, 1, 0);
        chk("lead_lag_zero_step", err_cnt, 2);
        ev(1, 0, 1);
        chk("lead_beats_both", err_cnt, 3);
        ev(0, 1, 1);
        chk("lag_beats_both", err_cnt, 2);
        repeat (2) ev(0, 1, 0);
        gap(2);
        chk("cancel_err0", err_cnt, 0);
        chk("cancel_no_add", add_seen - a0, 0);
        chk("cancel_no_plus", plus_seen - p0, 0);

        // Mid-operation disable.
        repeat (3) ev(1, 0, 0);
        chk("midop_err3", err_cnt, 3);
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        chk("midop_idle", state_o, 0);
        chk("midop_err0", err_cnt, 0);
`ifdef DPLL_LF_STATS_EN
        chk("stats_clr_add", n_add, 0);
        chk("stats_clr_plus", n_plus, 0);
`endif
        gap(1);
        chk("midop_reacq", state_o, 1);

        // Lock, then TRACK uses K_TRK.
        lock_seq();
        a0 = add_seen;
        for (int i = 0; i < 16; i++) begin
            ev(1, 0, 0);
            if (i == 14) begin
                chk("trk_err15", err_cnt, 15);
                chk("trk_no_add15", add_seen - a0, 0);
            end
        end
        chk("trk_add16", add, 1);
        chk("trk_still_locked", locked, 1);
        gap(2);
        chk("trk_add_once", add_seen - a0, 1);

        // Fresh lock for the unlock run.
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
        gap(1);
        chk("relock_acq", state_o, 1);
        lock_seq();

        // Unlock: three same-sign corrections in TRACK.
        a0 = add_seen;
        for (int i = 1; i <= 48; i++) begin
            ev(1, 0, 0);
            if (i == 16) begin
                chk("unl_add16", add, 1);
                chk("unl_state16", state_o, 2);
            end
            if (i == 32) chk("unl_add32", add, 1);
        end
        chk("unl_add48", add, 1);
        chk("unl_state_acq", state_o, 1);
        chk("unl_locked0", locked, 0);
        gap(2);
        chk("unl_add_count", add_seen - a0, 3);
        for (int i = 0; i < 4; i++) ev(1, 0, 0);
        chk("reacq_add_k4", add, 1);

        // Reset overrides a crossing in flight.
        repeat (3) ev(1, 0, 0);
        chk("rst_mid_err3", err_cnt, 3);
        @(negedge clk); lead = 1'b1; reset = 1'b1;
        @(negedge clk); lead = 1'b0;
        chk("rst_mid_no_add", add, 0);
        chk("rst_mid_err0", err_cnt, 0);
        chk("rst_mid_state", state_o, 0);
        reset = 1'b0;
        gap(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
